// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares the single-port sprite ROM between the four per-pixel sprite units
//   (0 = text, 1 = player, 2 = money, 3 = car). At most one read is issued per
//   clock. Each result is routed back to its issuer ROM_LAT+1 clocks after the
//   grant. Requester 0 has strict priority, bounded by an anti-starvation
//   counter. Requesters 1..N_REQ-1 share the remaining slots round-robin.
//
// Ports
//   Clk, Reset   : clock and asynchronous active-high reset
//   FrameStart   : one-cycle pulse; rewinds the round-robin pointer and the
//                  starvation counter
//   Req/ReqAddr  : per-requester request and flattened address
//                  (slice i = [i*ADDR_W +: ADDR_W])
//   Grant        : combinational one-hot grant for this cycle
//   RomRd/RomAddr: registered ROM read strobe and address
//   RomData      : ROM read data, valid ROM_LAT clocks after RomRd
//   RespValid    : one-hot owner of RespData this cycle
//   RespData     : pass-through of RomData
module sprite_rom_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 6,
    parameter int ROM_LAT    = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    FrameStart,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*ADDR_W-1:0] ReqAddr,
    output logic [N_REQ-1:0]        Grant,
    output logic                    RomRd,
    output logic [ADDR_W-1:0]       RomAddr,
    input  logic [DATA_W-1:0]       RomData,
    output logic [N_REQ-1:0]        RespValid,
    output logic [DATA_W-1:0]       RespData
);

    localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
    logic [N_REQ-1:0]  tag_d [ROM_LAT+1];

    logic              req_others;
    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_idx;
    logic [N_REQ-1:0]  grant_c;

    // Index of the k-th round-robin candidate, counting circularly over
    // 1..N_REQ-1 starting at ptr.
    function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] ptr,
                                                 input int               k);
        int s;
        s = ((int'(ptr) - 1 + k) % (N_REQ - 1)) + 1;
        return PTR_W'(s);
    endfunction

    // Grant selection
    always_comb begin
        req_others = |Req[N_REQ-1:1];
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        grant_c    = '0;
        if (Req[0] && ((starve_cnt_q < CNT_W'(STARVE_LIM)) || !req_others)) begin
            gnt_any = 1'b1;
        end else begin
            for (int k = 0; k < N_REQ - 1; k++) begin
                if (!gnt_any && Req[rr_slot(rr_ptr_q, k)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = rr_slot(rr_ptr_q, k);
                end
            end
            // Requester 0 throttled but nobody else asking: it still gets the slot.
            if (!gnt_any && Req[0]) begin
                gnt_any = 1'b1;
            end
        end
        if (gnt_any) begin
            grant_c[gnt_idx] = 1'b1;
        end
    end

    // Next-state: ROM command, tag pipeline, arbitration state
    always_comb begin
        rom_rd_d   = gnt_any;
        rom_addr_d = rom_addr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                rom_addr_d = ReqAddr[i*ADDR_W +: ADDR_W];
            end
        end

        // Stage 0 holds the tag of the read on the ROM bus; stage ROM_LAT lines
        // up with RomData for that read.
        tag_d[0] = grant_c;
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        if (FrameStart) begin
            rr_ptr_d     = PTR_W'(1);
            starve_cnt_d = '0;
        end else if (gnt_any && (gnt_idx != '0)) begin
            rr_ptr_d     = (gnt_idx == PTR_W'(N_REQ - 1)) ? PTR_W'(1)
                                                           : gnt_idx + PTR_W'(1);
            starve_cnt_d = '0;
        end else if (!req_others) begin
            starve_cnt_d = '0;
        end else if (gnt_any && (starve_cnt_q < CNT_W'(STARVE_LIM))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_rd_q     <= 1'b0;
            rom_addr_q   <= '0;
            rr_ptr_q     <= PTR_W'(1);
            starve_cnt_q <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            rom_rd_q     <= rom_rd_d;
            rom_addr_q   <= rom_addr_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign Grant     = grant_c;
    assign RomRd     = rom_rd_q;
    assign RomAddr   = rom_addr_q;
    assign RespValid = tag_q[ROM_LAT];
    assign RespData  = RomData;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

    localparam int N_REQ      = 4;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 6;
    localparam int ROM_LAT    = 2;
    localparam int STARVE_LIM = 8;

    logic                    Clk;
    logic                    Reset;
    logic                    FrameStart;
    logic [N_REQ-1:0]        Req;
    logic [N_REQ*ADDR_W-1:0] ReqAddr;
    logic [N_REQ-1:0]        Grant;
    logic                    RomRd;
    logic [ADDR_W-1:0]       RomAddr;
    logic [DATA_W-1:0]       RomData;
    logic [N_REQ-1:0]        RespValid;
    logic [DATA_W-1:0]       RespData;

    sprite_rom_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ROM_LAT(ROM_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .Clk(Clk), .Reset(Reset), .FrameStart(FrameStart),
        .Req(Req), .ReqAddr(ReqAddr), .Grant(Grant),
        .RomRd(RomRd), .RomAddr(RomAddr), .RomData(RomData),
        .RespValid(RespValid), .RespData(RespData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ROM contents: a fixed scramble of the address.
    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return DATA_W'(a ^ (a >> 6) ^ (a >> 12) ^ 15'h0015);
    endfunction

    // Behavioural ROM: data for a read appears ROM_LAT clocks after RomRd.
    logic [ADDR_W-1:0] apipe [ROM_LAT];
    logic              vpipe [ROM_LAT];
    always @(posedge Clk) begin
        apipe[0] <= RomAddr;
        vpipe[0] <= RomRd;
        for (int k = 1; k < ROM_LAT; k++) begin
            apipe[k] <= apipe[k-1];
            vpipe[k] <= vpipe[k-1];
        end
    end
    assign RomData = vpipe[ROM_LAT-1] ? rom_f(apipe[ROM_LAT-1]) : '1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected responses.
    typedef struct {
        int               due;
        logic [N_REQ-1:0] vld;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    always @(negedge Clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            chk("resp_valid", 32'(RespValid), 32'(sb[0].vld));
            chk("resp_data", 32'(RespData), 32'(sb[0].data));
            sb.delete(0);
        end else begin
            chk("resp_idle", 32'(RespValid), 32'd0);
        end
    end

    // Reference arbitration model.
    int m_ptr;
    int m_starve;
    logic [ADDR_W-1:0] addr_r [N_REQ];

    function automatic logic [N_REQ-1:0] onehot(input int g);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < N_REQ; i++) if (i == g) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int g);
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int i = 0; i < N_REQ; i++) if (i == g) a = addr_r[i];
        return a;
    endfunction

    function automatic int model_pick(input logic [N_REQ-1:0] r);
        bit others;
        int j;
        others = (r >> 1) != 0;
        if (r[0] && (m_starve < STARVE_LIM || !others)) return 0;
        for (int k = 0; k < N_REQ - 1; k++) begin
            j = m_ptr + k;
            if (j > N_REQ - 1) j = j - (N_REQ - 1);
            if ((r & onehot(j)) != 0) return j;
        end
        if (r[0]) return 0;
        return -1;
    endfunction

    task automatic model_update(input logic [N_REQ-1:0] r, input logic fs, input int g);
        if (fs) begin
            m_ptr = 1;
            m_starve = 0;
        end else if (g >= 1) begin
            m_ptr = (g == N_REQ - 1) ? 1 : g + 1;
            m_starve = 0;
        end else if ((r >> 1) == 0) begin
            m_starve = 0;
        end else if (g == 0 && m_starve < STARVE_LIM) begin
            m_starve++;
        end
    endtask

    task automatic model_reset();
        m_ptr = 1;
        m_starve = 0;
    endtask

    // One clock of stimulus, started just after a falling edge.
    // want >= -1 also compares Grant against a directed constant (-1 = none).
    task automatic step(input logic [N_REQ-1:0] req, input logic fs, input int want,
                        input bit rst_mid, output int g);
        logic [N_REQ-1:0]  exp_g;
        logic [ADDR_W-1:0] exp_a;
        Req = req;
        FrameStart = fs;
        for (int i = 0; i < N_REQ; i++) ReqAddr[i*ADDR_W +: ADDR_W] = addr_r[i];
        #1;
        g = model_pick(req);
        exp_g = (g >= 0) ? onehot(g) : '0;
        exp_a = addr_of(g);
        chk("grant", 32'(Grant), 32'(exp_g));
        if (want >= -1) chk("grant_directed", 32'(Grant), 32'((want >= 0) ? onehot(want) : '0));
        if (rst_mid) begin
            #1 Reset = 1'b1;
            #1;
            chk("rst_romrd_async", 32'(RomRd), 32'd0);
            sb.delete();
            model_reset();
            @(negedge Clk);
            chk("rst_romrd", 32'(RomRd), 32'd0);
            chk("rst_romaddr", 32'(RomAddr), 32'd0);
            Reset = 1'b0;
            g = -1;
        end else begin
            if (g >= 0) sb.push_back('{due: cyc + ROM_LAT + 1, vld: exp_g, data: rom_f(exp_a)});
            model_update(req, fs, g);
            @(negedge Clk);
            chk("romrd", 32'(RomRd), (g >= 0) ? 32'd1 : 32'd0);
            if (g >= 0) chk("romaddr", 32'(RomAddr), 32'(exp_a));
        end
        for (int i = 0; i < N_REQ; i++) if (i == g) addr_r[i] = ADDR_W'($urandom);
    endtask

    task automatic run(input logic [N_REQ-1:0] req, input logic fs, input int want);
        int g;
        step(req, fs, want, 1'b0, g);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0] pend;
        int g;
        Reset = 1'b1;
        FrameStart = 1'b0;
        Req = '0;
        ReqAddr = '0;
        for (int i = 0; i < N_REQ; i++) addr_r[i] = ADDR_W'($urandom);
        model_reset();
        #1;
        chk("reset_romrd", 32'(RomRd), 32'd0);
        chk("reset_romaddr", 32'(RomAddr), 32'd0);
        chk("reset_respvalid", 32'(RespValid), 32'd0);
        chk("reset_grant", 32'(Grant), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Single request from requester 2
        addr_r[2] = 15'h1234;
        run(4'b0100, 1'b0, 2);
        repeat (5) run(4'b0000, 1'b0, -1);

        // Round-robin among 1..3
        run(4'b0000, 1'b1, -1);
        for (int i = 0; i < 6; i++) run(4'b1110, 1'b0, (i % 3) + 1);

        // Anti-starvation with everyone asking, then requester 0 alone
        run(4'b0000, 1'b1, -1);
        for (int i = 0; i < 36; i++) run(4'b1111, 1'b0, (i % 9 == 8) ? 1 + (i / 9) % 3 : 0);
        for (int i = 0; i < 12; i++) run(4'b0001, 1'b0, 0);

        // FrameStart: same-cycle grant follows old pointer
        run(4'b0100, 1'b0, 2);
        run(4'b1110, 1'b1, 3);
        run(4'b1110, 1'b0, 1);
        run(4'b0010, 1'b0, 1);
        run(4'b0100, 1'b1, 2);
        run(4'b1110, 1'b0, 1);

        // Reset with reads in flight
        run(4'b0000, 1'b1, -1);
        run(4'b1110, 1'b0, 1);
        run(4'b1110, 1'b0, 2);
        step(4'b1110, 1'b0, 3, 1'b1, g);
        run(4'b1110, 1'b0, 1);
        repeat (4) run(4'b0000, 1'b0, -1);

        // Idle gaps
        for (int i = 0; i < 10; i++) run((i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0, (i % 2 == 0) ? 2 : -1);

        // Randomized traffic with held requests
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend[0]) pend[0] = ($urandom_range(0, 7) != 0);
            for (int i = 1; i < N_REQ; i++) if (!pend[i]) pend[i] = ($urandom_range(0, 3) == 0);
            step(pend, ($urandom_range(0, 15) == 0), -2, 1'b0, g);
            for (int i = 0; i < N_REQ; i++) if (i == g) pend[i] = 1'b0;
        end

        repeat (ROM_LAT + 4) run(4'b0000, 1'b0, -1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the single-port sprite ROM between the four per-pixel sprite units that feed palette indices to the colour mapper: text, player, money and car.
- Issues at most one ROM read per clock.
- Returns each read result to the unit that issued it after a fixed latency.
- Requester 0 (text) has strict priority, with an anti-starvation limit. Requesters 1..3 (player, money, car) are served round-robin.

Parameters:
- N_REQ, 4, number of requesters; index 0 is the priority requester.
- ADDR_W, 15, sprite ROM address width.
- DATA_W, 6, ROM data width (palette index).
- ROM_LAT, 2, clocks from RomRd asserted to RomData valid; must be >= 1.
- STARVE_LIM, 8, maximum consecutive requester-0 grants while any of 1..3 is waiting.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, asynchronous active-high reset.
- FrameStart, in, 1, one-cycle pulse at the start of each frame.
- Req, in, N_REQ, per-requester read request; held high until granted.
- ReqAddr, in, N_REQ*ADDR_W, flattened addresses; slice i = [i*ADDR_W +: ADDR_W].
- Grant, out, N_REQ, one-hot combinational grant for the current cycle; all zero if no Req.
- RomRd, out, 1, registered ROM read strobe.
- RomAddr, out, ADDR_W, registered ROM address.
- RomData, in, DATA_W, ROM read data, valid ROM_LAT clocks after RomRd.
- RespValid, out, N_REQ, one-hot; marks the requester that owns RespData this cycle.
- RespData, out, DATA_W, equals RomData (pass-through), qualified by RespValid.

Behaviour:
- Reset values:
  - RomRd=0, RomAddr=0, RespValid=0.
  - Tag pipeline cleared.
  - rr_ptr=1; starve_cnt=0.
  - Grant is combinational, so it is zero whenever Req=0.
- Grant selection (combinational, per cycle):
  - If Req[0]=1 and (starve_cnt<STARVE_LIM or Req[N_REQ-1:1]==0): grant 0.
  - Otherwise, grant the first set Req[j] among 1..N_REQ-1, searching circularly from rr_ptr.
  - If none of those is set but Req[0]=1, grant 0.
- Requester handshake:
  - A requester sees Grant[i]=1 in the same cycle its Req is high.
  - It may drop Req or present a new address on the next cycle.
  - An ungranted requester must keep Req and ReqAddr stable.
- On each rising edge with any grant g:
  - RomRd<=1 and RomAddr<=ReqAddr slice g.
  - Tag g is pushed into a ROM_LAT+1 deep shift pipeline.
  - With no grant: RomRd<=0 and an empty tag is pushed.
- RespValid[g] is asserted exactly ROM_LAT+1 clocks after the cycle in which Grant[g] was high; RespData is valid in that same cycle.
  - Total latency from Req-grant to response is ROM_LAT+1 (3 by default).
  - Fully pipelined: back-to-back grants yield back-to-back responses, in grant order.
- rr_ptr update, on an edge where the grant is in 1..N_REQ-1:
  - rr_ptr<=g+1, wrapping from N_REQ-1 back to 1.
  - Unchanged when grant is 0 or there is no grant.
- starve_cnt update:
  - Increments, saturating at STARVE_LIM, on an edge where grant=0 while any of Req[N_REQ-1:1] is set.
  - Clears on any grant to 1..N_REQ-1.
  - Clears on a cycle in which none of 1..N_REQ-1 is requesting.
- FrameStart:
  - On that edge, rr_ptr<=1 and starve_cnt<=0.
  - This overrides the pointer and counter updates above.
  - The grant made in the same cycle still issues normally.
  - Responses already in flight are not disturbed.
- Reset mid-operation:
  - All in-flight tags are discarded and no RespValid is produced for them.
  - RomRd drops asynchronously.
- Width rules: tag pipeline stores a one-hot N_REQ vector per stage; starve_cnt is $clog2(STARVE_LIM+1) bits.

Test Plan:
- Single request: after reset, Req=0100, slice2=15'h1234. Expect Grant=0100 that cycle; RomRd=1, RomAddr=15'h1234 next cycle; RespValid=0100 three cycles after grant with RespData=RomData. No other RespValid pulses.
- Round-robin: Req=1110 held, with each address distinct. Expect the grant order 1,2,3,1,2,3 and the matching RespValid order three cycles later, with RomRd continuously high.
- Anti-starvation: Req=1111 held. Expect 8 grants to 0, then one to 1, then 8 to 0, then one to 2, and so on. With Req=0001 only, expect requester 0 granted every cycle indefinitely.
- FrameStart: set rr_ptr=3 via a prior grant to 2, then pulse FrameStart while Req=1110. The same-cycle grant follows the old pointer (3); the next grant is to 1.
- Reset mid-flight: grant 3 requests back-to-back, then assert Reset for one cycle on the edge after the last grant. Expect RespValid to stay 0 throughout, and RomRd, RomAddr and rr_ptr to return to their reset values.
- Idle gaps: Req pulses to requester 2 on alternate cycles. RespValid=0100 also appears on alternate cycles, with RomRd=0 in the gaps.
